// File: rtl/uart_receptor_jogo_pkg.sv
// Shared definitions for the game-status UART receiver: word layout and byte FSM state codes.
package uart_receptor_jogo_pkg;

  localparam int WORD_W = 16;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  typedef struct packed {
    logic [3:0] estado;
    logic [3:0] macro;
    logic [3:0] micro;
    logic [1:0] resultado_macro;
    logic [1:0] resultado_jogo;
  } status_t;

endpackage

// File: rtl/uart_receptor_jogo_rx_byte.sv
// 8N1 byte receiver: 2-FF synchroniser on the serial line, then a mid-bit sampling FSM.
module uart_receptor_jogo_rx_byte
  import uart_receptor_jogo_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       s_in,
  output logic [7:0] rx_byte,
  output logic       byte_done,
  output logic       frame_err,
  output logic       active
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  logic [1:0]       sync_reg;
  logic [1:0]       state_reg;
  logic [CNT_W-1:0] clk_cnt_reg;
  logic [2:0]       bit_cnt_reg;
  logic [7:0]       shift_reg;
  logic             rearm_reg;
  logic             byte_done_reg;
  logic             frame_err_reg;
  logic             rx;

  assign rx = sync_reg[1];

  always_ff @(posedge clock) begin
    if (!reset) begin
      sync_reg      <= 2'b11;
      state_reg     <= ST_IDLE;
      clk_cnt_reg   <= '0;
      bit_cnt_reg   <= '0;
      shift_reg     <= '0;
      rearm_reg     <= 1'b0;
      byte_done_reg <= 1'b0;
      frame_err_reg <= 1'b0;
    end else begin
      sync_reg      <= {sync_reg[0], s_in};
      byte_done_reg <= 1'b0;
      frame_err_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          clk_cnt_reg <= '0;
          bit_cnt_reg <= '0;
          // After a bad stop bit the line may still be low; wait for idle before re-arming.
          if (rearm_reg) begin
            if (rx) rearm_reg <= 1'b0;
          end else if (!rx) begin
            state_reg <= ST_START;
          end
        end
        ST_START: begin
          if (clk_cnt_reg == HALF_LAST) begin
            clk_cnt_reg <= '0;
            state_reg   <= rx ? ST_IDLE : ST_DATA;
          end else begin
            clk_cnt_reg <= clk_cnt_reg + 1'b1;
          end
        end
        ST_DATA: begin
          if (clk_cnt_reg == FULL_LAST) begin
            clk_cnt_reg <= '0;
            shift_reg   <= {rx, shift_reg[7:1]};
            bit_cnt_reg <= bit_cnt_reg + 1'b1;
            if (bit_cnt_reg == 3'd7) state_reg <= ST_STOP;
          end else begin
            clk_cnt_reg <= clk_cnt_reg + 1'b1;
          end
        end
        ST_STOP: begin
          if (clk_cnt_reg == FULL_LAST) begin
            clk_cnt_reg <= '0;
            state_reg   <= ST_IDLE;
            if (rx) begin
              byte_done_reg <= 1'b1;
            end else begin
              frame_err_reg <= 1'b1;
              rearm_reg     <= 1'b1;
            end
          end else begin
            clk_cnt_reg <= clk_cnt_reg + 1'b1;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign rx_byte   = shift_reg;
  assign byte_done = byte_done_reg;
  assign frame_err = frame_err_reg;
  assign active    = (state_reg != ST_IDLE);

endmodule

// File: rtl/uart_receptor_jogo.sv
// Game-status link receiver: pairs two UART bytes (high first) into a 16-bit status word,
// dropping a lone high byte after an idle timeout.
module uart_receptor_jogo
  import uart_receptor_jogo_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              s_in,
  output logic [WORD_W-1:0] o_data,
  output logic [3:0]        o_estado,
  output logic [3:0]        o_macro,
  output logic [3:0]        o_micro,
  output logic [1:0]        o_resultado_macro,
  output logic [1:0]        o_resultado_jogo,
  output logic              valid,
  output logic              frame_error,
  output logic              busy
);

  localparam int TO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TO_W     = $clog2(TO_LIMIT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_LIMIT - 1);

  logic [7:0]      rx_byte;
  logic            byte_done;
  logic            frame_err;
  logic            rx_active;

  logic            index_reg;
  logic [7:0]      hi_reg;
  logic [TO_W-1:0] to_cnt_reg;
  status_t         data_reg;
  logic            valid_reg;
  logic            frame_error_reg;

  uart_receptor_jogo_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx_byte (
    .clock    (clock),
    .reset    (reset),
    .s_in     (s_in),
    .rx_byte  (rx_byte),
    .byte_done(byte_done),
    .frame_err(frame_err),
    .active   (rx_active)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      index_reg       <= 1'b0;
      hi_reg          <= '0;
      to_cnt_reg      <= '0;
      data_reg        <= '0;
      valid_reg       <= 1'b0;
      frame_error_reg <= 1'b0;
    end else begin
      valid_reg       <= 1'b0;
      frame_error_reg <= 1'b0;
      if (frame_err) begin
        index_reg       <= 1'b0;
        frame_error_reg <= 1'b1;
      end else if (byte_done) begin
        if (!index_reg) begin
          hi_reg     <= rx_byte;
          index_reg  <= 1'b1;
          to_cnt_reg <= '0;
        end else begin
          data_reg  <= {hi_reg, rx_byte};
          valid_reg <= 1'b1;
          index_reg <= 1'b0;
        end
      end else if (index_reg && !rx_active) begin
        // Counter stops at its last value because the index drops there, so it never wraps.
        if (to_cnt_reg == TO_LAST) index_reg <= 1'b0;
        else                       to_cnt_reg <= to_cnt_reg + 1'b1;
      end
    end
  end

  assign o_data            = data_reg;
  assign o_estado          = data_reg.estado;
  assign o_macro           = data_reg.macro;
  assign o_micro           = data_reg.micro;
  assign o_resultado_macro = data_reg.resultado_macro;
  assign o_resultado_jogo  = data_reg.resultado_jogo;
  assign valid             = valid_reg;
  assign frame_error       = frame_error_reg;
  assign busy              = rx_active || index_reg;

endmodule

// File: tb/tb_uart_receptor_jogo.sv
// Scoreboard bench for uart_receptor_jogo: protocol-level model feeds expected words/errors,
// a negedge monitor pops and compares whenever valid or frame_error fires.
module tb_uart_receptor_jogo;

  localparam int CPB = 8;
  localparam int TOB = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        s_in  = 1'b1;
  logic [15:0] o_data;
  logic [3:0]  o_estado, o_macro, o_micro;
  logic [1:0]  o_resultado_macro, o_resultado_jogo;
  logic        valid, frame_error, busy;

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_words[$];
  int          exp_ferr     = 0;
  int          n_expected   = 0;
  int          n_valid      = 0;
  logic [15:0] last_word    = 16'h0;
  bit          have_hi      = 0;
  logic [7:0]  model_hi     = 8'h0;

  uart_receptor_jogo #(.CLKS_PER_BIT(CPB), .TIMEOUT_BITS(TOB)) dut (
    .clock(clock), .reset(reset), .s_in(s_in), .o_data(o_data),
    .o_estado(o_estado), .o_macro(o_macro), .o_micro(o_micro),
    .o_resultado_macro(o_resultado_macro), .o_resultado_jogo(o_resultado_jogo),
    .valid(valid), .frame_error(frame_error), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Protocol-level model: a pair of good bytes makes a word; an idle gap longer than the
  // timeout drops a pending high byte; a bad stop bit drops everything pending.
  task automatic model_byte(input logic [7:0] b, input bit stop_ok, input int gap_bits);
    if (have_hi && gap_bits > TOB) have_hi = 0;
    if (!stop_ok) begin
      exp_ferr++;
      have_hi = 0;
    end else if (!have_hi) begin
      have_hi  = 1;
      model_hi = b;
    end else begin
      exp_words.push_back({model_hi, b});
      n_expected++;
      have_hi = 0;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    s_in = 1'b0;
    repeat (CPB) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      s_in = b[i];
      repeat (CPB) @(negedge clock);
    end
    s_in = stop_bit;
    repeat (CPB) @(negedge clock);
    s_in = 1'b1;
  endtask

  task automatic tx(input logic [7:0] b, input bit stop_ok, input int gap_bits);
    model_byte(b, stop_ok, gap_bits);
    send_byte(b, stop_ok ? 1'b1 : 1'b0);
  endtask

  task automatic idle_bits(input int n);
    s_in = 1'b1;
    repeat (n * CPB) @(negedge clock);
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && (exp_words.size() != 0 || exp_ferr != 0); i++) @(negedge clock);
    chk("drain_words", exp_words.size(), 0);
    chk("drain_ferr", exp_ferr, 0);
  endtask

  task automatic check_zero_outputs();
    chk("rst_data", o_data, 16'h0);
    chk("rst_estado", o_estado, 4'h0);
    chk("rst_res_jogo", o_resultado_jogo, 2'h0);
    chk("rst_valid", valid, 1'b0);
    chk("rst_ferr", frame_error, 1'b0);
    chk("rst_busy", busy, 1'b0);
  endtask

  // Monitor
  always @(negedge clock) begin
    if (reset && valid) begin
      if (exp_words.size() == 0) begin
        chk("unexpected_valid", o_data, 32'hFFFF_FFFF);
      end else begin
        logic [15:0] w;
        w = exp_words.pop_front();
        n_valid++;
        chk("o_data", o_data, w);
        chk("o_estado", o_estado, w[15:12]);
        chk("o_macro", o_macro, w[11:8]);
        chk("o_micro", o_micro, w[7:4]);
        chk("o_res_macro", o_resultado_macro, w[3:2]);
        chk("o_res_jogo", o_resultado_jogo, w[1:0]);
        last_word = w;
      end
    end
    if (reset && frame_error) begin
      if (exp_ferr == 0) begin
        chk("unexpected_frame_error", 1, 0);
      end else begin
        exp_ferr--;
        chk("data_hold_on_ferr", o_data, last_word);
        chk("no_valid_with_ferr", valid, 1'b0);
      end
    end
  end

  initial begin
    int busy_cnt;
    logic [15:0] rw;
    reset = 1'b0;
    s_in  = 1'b1;
    repeat (4) @(negedge clock);
    check_zero_outputs();
    reset = 1'b1;
    idle_bits(2);

    // 1: basic pair
    tx(8'hA5, 1, 0);
    tx(8'h3C, 1, 0);
    idle_bits(2);
    drain();

    // 2: short glitch is ignored, then a normal pair
    s_in = 1'b0;
    repeat (2) @(negedge clock);
    s_in = 1'b1;
    busy_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clock);
      if (busy) busy_cnt++;
    end
    chk("glitch_busy_seen", (busy_cnt >= 1) ? 1 : 0, 1);
    chk("glitch_busy_le4", (busy_cnt <= 4) ? 1 : 0, 1);
    tx(8'hC3, 1, 0);
    tx(8'h96, 1, 0);
    idle_bits(2);
    drain();

    // 3: bad stop bit on byte 1, then recovery
    tx(8'h12, 1, 0);
    tx(8'h99, 0, 0);
    idle_bits(3);
    drain();
    tx(8'h12, 1, 3);
    tx(8'h34, 1, 0);
    idle_bits(2);
    drain();

    // 4: lone byte times out
    tx(8'h77, 1, 2);
    idle_bits(5);
    chk("timeout_busy_low", busy, 1'b0);
    tx(8'h0F, 1, 5);
    tx(8'hF0, 1, 0);
    idle_bits(2);
    drain();

    // 5: reset during the data bits of byte 1
    tx(8'h5A, 1, 2);
    s_in = 1'b0;
    repeat (CPB) @(negedge clock);
    for (int i = 0; i < 3; i++) begin
      s_in = i[0];
      repeat (CPB) @(negedge clock);
    end
    reset = 1'b0;
    have_hi   = 0;
    last_word = 16'h0;
    repeat (2) @(negedge clock);
    s_in  = 1'b1;
    reset = 1'b1;
    @(negedge clock);
    check_zero_outputs();
    idle_bits(2);
    tx(8'hDE, 1, 2);
    tx(8'hAD, 1, 0);
    idle_bits(2);
    drain();

    // 6: random back-to-back words
    for (int k = 0; k < 100; k++) begin
      rw = 16'($urandom);
      tx(rw[15:8], 1, 0);
      tx(rw[7:0], 1, 0);
    end
    idle_bits(2);
    drain();
    chk("valid_count", n_valid, n_expected);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
